// File: rtl/dii_package.sv
`default_nettype none
// ============================================================================
// Module   : dii_package
// Purpose  : Debug interconnect flit type shared by all debug modules.
//            A flit is one 16-bit word plus its handshake valid and the
//            end-of-packet marker.
// Revision : 1.0 - initial release
// ============================================================================
package dii_package;

    typedef struct packed {
        logic [15:0] data;
        logic        valid;
        logic        last;
    } dii_flit;

endpackage : dii_package
`default_nettype wire

// File: rtl/mam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mam_pkg
// Purpose  : Shared definitions for the MAM request packetizer: MAM header
//            bit layout, debug packet type for header flit 1, address flit
//            count helper and the packetizer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mam_pkg;

    // MAM request header flit layout
    localparam int C_MAM_HDR_RW_BIT    = 15;
    localparam int C_MAM_HDR_BURST_BIT = 14;
    localparam int C_MAM_HDR_BEATS_MSB = 13;

    // Debug packet type carried in bits [15:14] of header flit 1
    localparam logic [1:0] C_DII_TYPE_REQ = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_MHDR = 3'd3,
        ST_ADDR = 3'd4,
        ST_DATA = 3'd5
    } mam_tx_state_e;

    // Number of 16-bit flits needed to carry an address
    function automatic int addr_flits(input int addr_width);
        return addr_width / 16;
    endfunction

endpackage : mam_pkg
`default_nettype wire

// File: rtl/mam_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : mam_pkt_tx
// Purpose  : Host-side MAM request packetizer. Takes one access request
//            (rw, burst, beats, address) plus a write data stream and emits
//            the matching MAM debug packets. Writes longer than one packet
//            are split into continuation packets (HDR0, HDR1, data only).
// Ports    : clk, rst_n            - clock, async active-low reset
//            src_id, dest_id       - own / target debug ids
//            req_*                 - request handshake and fields
//            wdata_valid/_ready    - write word stream
//            debug_out(_ready)     - dii_flit output with sink ready
// Revision : 1.0 - initial release
// ============================================================================
module mam_pkt_tx
    import mam_pkg::*;
    import dii_package::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            src_id,
    input  logic [9:0]            dest_id,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic                  req_burst,
    input  logic [13:0]           req_beats,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wdata_valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ready,
    output dii_flit               debug_out,
    input  logic                  debug_out_ready
);

    localparam int C_AF  = addr_flits(ADDR_WIDTH);
    localparam int C_SF  = DATA_WIDTH / 16;
    localparam int C_AIW = (C_AF > 1) ? $clog2(C_AF) : 1;
    localparam int C_SIW = (C_SF > 1) ? $clog2(C_SF) : 1;
    localparam int C_PCW = $clog2(MAX_PKT_LEN);

    localparam logic [C_AIW-1:0] C_AIDX_LAST = C_AIW'(C_AF - 1);
    localparam logic [C_SIW-1:0] C_SIDX_LAST = C_SIW'(C_SF - 1);
    localparam logic [C_PCW-1:0] C_PKT_LAST  = C_PCW'(MAX_PKT_LEN - 1);

    generate
        if (MAX_PKT_LEN < 4 + C_AF) begin : g_bad_pkt_len
            $error("mam_pkt_tx: MAX_PKT_LEN must be at least 4 + ADDR_WIDTH/16");
        end
        if ((DATA_WIDTH % 16 != 0) || (ADDR_WIDTH % 16 != 0)) begin : g_bad_width
            $error("mam_pkt_tx: DATA_WIDTH and ADDR_WIDTH must be multiples of 16");
        end
    endgenerate

    mam_tx_state_e           state_q, state_d;
    logic                    rw_q, rw_d;
    logic                    burst_q, burst_d;
    logic [13:0]             beats_q, beats_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [13:0]             words_left_q, words_left_d;
    logic [C_PCW-1:0]        pkt_cnt_q, pkt_cnt_d;
    logic [C_AIW-1:0]        aidx_q, aidx_d;
    logic [C_SIW-1:0]        sidx_q, sidx_d;
    logic                    cont_q, cont_d;
    logic                    req_ready_q, req_ready_d;

    logic [15:0] flit_data;
    logic        flit_valid;
    logic        flit_last;
    logic        fire;
    logic        no_data;
    logic        word_end;
    logic        req_end;
    logic        pkt_full;

    // A request carries no data when it is a read or a zero-beat burst write
    assign no_data  = !rw_q || (words_left_q == 14'd0);
    assign word_end = (sidx_q == C_SIDX_LAST);
    assign req_end  = word_end && (words_left_q == 14'd1);
    assign pkt_full = (pkt_cnt_q == C_PKT_LAST);
    assign fire     = flit_valid && debug_out_ready;

    // Flit content is a pure function of registered state, so it holds
    // steady under backpressure; only DATA forwards the word stream.
    always_comb begin
        flit_data  = 16'h0;
        flit_valid = 1'b0;
        flit_last  = 1'b0;
        unique case (state_q)
            ST_HDR0: begin
                flit_valid = 1'b1;
                flit_data  = {6'h0, dest_id};
            end
            ST_HDR1: begin
                flit_valid = 1'b1;
                flit_data  = {C_DII_TYPE_REQ, 4'h0, src_id};
            end
            ST_MHDR: begin
                flit_valid = 1'b1;
                flit_data[C_MAM_HDR_RW_BIT]       = rw_q;
                flit_data[C_MAM_HDR_BURST_BIT]    = burst_q;
                flit_data[C_MAM_HDR_BEATS_MSB:0]  = burst_q ? beats_q : 14'h0;
            end
            ST_ADDR: begin
                flit_valid = 1'b1;
                for (int i = 0; i < C_AF; i++) begin
                    if (aidx_q == C_AIW'(i)) flit_data = addr_q[(C_AF-1-i)*16 +: 16];
                end
                flit_last = (aidx_q == C_AIDX_LAST) && no_data;
            end
            ST_DATA: begin
                flit_valid = wdata_valid;
                for (int i = 0; i < C_SF; i++) begin
                    if (sidx_q == C_SIW'(i)) flit_data = wdata[(C_SF-1-i)*16 +: 16];
                end
                flit_last = req_end || pkt_full;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        burst_d      = burst_q;
        beats_d      = beats_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        pkt_cnt_d    = pkt_cnt_q;
        aidx_d       = aidx_q;
        sidx_d       = sidx_q;
        cont_d       = cont_q;

        if (state_q == ST_IDLE) begin
            if (req_valid && req_ready_q) begin
                rw_d         = req_rw;
                burst_d      = req_burst;
                beats_d      = req_beats;
                addr_d       = req_addr;
                words_left_d = req_burst ? req_beats : 14'd1;
                pkt_cnt_d    = '0;
                aidx_d       = '0;
                sidx_d       = '0;
                cont_d       = 1'b0;
                state_d      = ST_HDR0;
            end
        end else if (fire) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
            unique case (state_q)
                ST_HDR0: state_d = ST_HDR1;
                // Continuation packets skip MHDR and ADDR entirely
                ST_HDR1: state_d = cont_q ? ST_DATA : ST_MHDR;
                ST_MHDR: state_d = ST_ADDR;
                ST_ADDR: begin
                    if (aidx_q == C_AIDX_LAST) begin
                        state_d = no_data ? ST_IDLE : ST_DATA;
                    end else begin
                        aidx_d = aidx_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    // Sub-flit index survives a packet split so a word may
                    // straddle two packets.
                    if (word_end) begin
                        sidx_d       = '0;
                        words_left_d = words_left_q - 14'd1;
                    end else begin
                        sidx_d = sidx_q + 1'b1;
                    end
                    if (req_end) begin
                        state_d = ST_IDLE;
                    end else if (pkt_full) begin
                        state_d   = ST_HDR0;
                        cont_d    = 1'b1;
                        pkt_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rw_q         <= 1'b0;
            burst_q      <= 1'b0;
            beats_q      <= 14'h0;
            addr_q       <= '0;
            words_left_q <= 14'h0;
            pkt_cnt_q    <= '0;
            aidx_q       <= '0;
            sidx_q       <= '0;
            cont_q       <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            burst_q      <= burst_d;
            beats_q      <= beats_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            pkt_cnt_q    <= pkt_cnt_d;
            aidx_q       <= aidx_d;
            sidx_q       <= sidx_d;
            cont_q       <= cont_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign wdata_ready = (state_q == ST_DATA) && debug_out_ready && word_end;
    assign debug_out   = '{data: flit_data, valid: flit_valid, last: flit_last};

endmodule : mam_pkt_tx
`default_nettype wire

// File: doc/mam_pkt_tx.md
Name: mam_pkt_tx

Overview:
Host-side MAM request packetizer. It accepts one memory access request (rw, address, burst length) plus a stream of write data words, and emits the corresponding MAM debug packets as dii_flit on a valid/ready debug output. These are exactly the flit sequences osd_mam decodes. Writes that exceed one packet are split into continuation packets. It sits between a host/bridge request source and the debug interconnect ring.

Parameters:
DATA_WIDTH, 16, write data word width; multiple of 16; each word is sent as DATA_WIDTH/16 flits, MSB flit first.
ADDR_WIDTH, 32, address width; multiple of 16; sent as ADDR_WIDTH/16 flits, MSB flit first.
MAX_PKT_LEN, 8, maximum flits per packet including headers. Elaboration error if < 4 + ADDR_WIDTH/16.

Ports:
clk  in  1  clock
rst_n  in  1  reset
src_id  in  10  own debug id, placed in header flit 1
dest_id  in  10  target MAM id, placed in header flit 0
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_rw  in  1  1 = write, 0 = read
req_burst  in  1  1 = burst, 0 = single
req_beats  in  14  burst length in words (ignored when req_burst = 0)
req_addr  in  ADDR_WIDTH  start address
wdata_valid  in  1  write word valid
wdata  in  DATA_WIDTH  write word
wdata_ready  out  1  word consumed when wdata_valid && wdata_ready
debug_out  out  dii_flit  {data[15:0], valid, last}
debug_out_ready  in  1  sink ready

Interface rule (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: async on rst_n low. State goes to IDLE. req_ready=0 while rst_n low, then 1. wdata_ready=0. debug_out.valid=0, last=0, data=0. Any in-flight packet is abandoned with no last flit.
- Request latch: in IDLE, req_ready=1. On the handshake, latch rw, burst, beats, addr. Set words_left = burst ? beats : 1.
- FSM states: IDLE, HDR0, HDR1, MHDR, ADDR, DATA.
- Normal sequence: IDLE -> HDR0 -> HDR1 -> MHDR -> ADDR (ADDR_WIDTH/16 flits) -> DATA. Every state advances only on debug_out.valid && debug_out_ready.
- Flit contents:
  - HDR0 = {6'h0, dest_id}.
  - HDR1 = {2'b01, 4'h0, src_id}.
  - MHDR = {rw, burst, burst ? beats : 14'h0}.
- In HDR0/HDR1/MHDR/ADDR, valid=1 and data/last are held stable until accepted.
- Read (rw=0), or burst with beats=0: last=1 on the final ADDR flit, then IDLE. No data flits.
- DATA state:
  - debug_out.valid = wdata_valid (combinational). Bubbles are allowed; headers are not re-sent after a bubble.
  - Flit = word slice selected by a sub-flit counter.
  - wdata_ready = debug_out_ready in DATA and only on the last sub-flit of the word.
- Packet length: pkt_cnt counts flits of the current packet and resets at each packet start.
  - last=1 when pkt_cnt == MAX_PKT_LEN-1, or on the final sub-flit of the final word.
  - If last is due to the length limit and data remains, go to HDR0 for a continuation packet: HDR0, HDR1, then DATA, with no MHDR or ADDR.
  - Words may straddle a packet boundary; the sub-flit counter is preserved across the boundary.
- After the final flit of a request is accepted, go to IDLE; req_ready=1 on the next cycle. Minimum one idle cycle between requests.
- debug_out_ready low: all outputs hold; nothing is consumed.
- Counters:
  - words_left: 14 bits, decremented on each word handshake.
  - pkt_cnt: $clog2(MAX_PKT_LEN) bits.
  - Address flit index and sub-flit index: $clog2 of the respective flit counts, min 1 bit.

Decomposition:
- mam_pkg:
  - MAM header bit positions (RW=15, BURST=14, BEATS=13:0).
  - Debug packet TYPE constant 2'b01 for header flit 1.
  - Function addr_flits(ADDR_WIDTH).
  - FSM state enum.
- dii_flit comes from dii_package.
- Optional sub-module mam_flit_ser: serializes DATA_WIDTH words into 16-bit flits with valid/ready and a last-sub-flit flag. The FSM and packet splitting stay in mam_pkt_tx.

Test Plan (all with dest_id=5, src_id=0):
- Single write: addr 0x0, wdata 0x000F -> 0005,4000,8000,0000,0000,000F(last); req_ready high again next cycle.
- Burst write: beats=6, addr 0, data 0..5 -> 0005,4000,C006,0000,0000,0000,0001,0002(last) then 0005,4000,0003,0004,0005(last).
- Burst read: beats=4, addr 0x12345678 -> 0005,4000,4004,1234,5678(last); wdata_ready never asserts.
- Backpressure: debug_out_ready=0 for 5 cycles while flit 3 is valid -> data stays 0000 with valid held, no flit lost or duplicated. wdata_valid gap of 3 cycles in DATA -> valid drops, then resumes with no repeated header.
- DATA_WIDTH=32, single write 0xDEADBEEF -> data flits DEAD, BEEF(last); exactly one wdata handshake, on BEEF acceptance.
- Reset mid-packet: rst_n low after MHDR is accepted -> valid=0 immediately. After release, a new single write produces a clean 6-flit packet.
